// File: rtl/ram_pkg.sv
// Shared types and limits for the cache-side RAM controller.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } ram_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } ram_op_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_WIDTH   = 4;

  // A simultaneous read and write request resolves to a write.
  function automatic ram_op_t select_op(input logic re, input logic we);
    select_op = (we || !re) ? OP_WRITE : OP_READ;
    if (!we) select_op = OP_READ;
  endfunction

endpackage

// File: rtl/component_register.sv
// Enabled register with asynchronous clear, used for the read-data holding register.
module component_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = en ? d : q_q;
  end

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ram_controller.sv
// Fixed-latency single-port RAM controller with a four-phase re/we/ack handshake.
module ram_controller
  import ram_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  ack,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("ram_controller: LATENCY=%0d is outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  ram_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  ram_op_t               op_q, op_d;
  logic                  mem_we;
  logic                  rd_done;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    mem_we  = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (re || we) begin
          addr_d  = addr;
          wdata_d = data_in;
          op_d    = select_op(re, we);
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Bus inputs are deliberately not looked at here; the latched copies drive the access.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          mem_we  = (op_q == OP_WRITE);
          rd_done = (op_q == OP_READ);
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (!re && !we) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  end

  // NOTE: the array is intentionally left out of reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= wdata_q;
  end

  component_register #(
    .WIDTH(WIDTH)
  ) u_dout_reg (
    .clk (clk),
    .rst (rst),
    .en  (rd_done),
    .d   (mem_q[addr_q]),
    .q   (data_out)
  );

  assign ack  = (state_q == RESPOND);
  assign busy = (state_q != IDLE);

endmodule

// File: doc/ram_controller.md
RAM_CONTROLLER -- requirements
Module: ram_controller

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; matches the cache WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 8, word address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter LATENCY, default 4, array access cycles; legal range 1..15; elaboration SHALL fail outside it.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 re  input  1  read request from the cache.
REQ-007 we  input  1  write request from the cache (the cache's RAM_we).
REQ-008 addr  input  ADDR_WIDTH  word address of the request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 data_out  output  WIDTH  read data, feeds the cache's data_from_RAM.
REQ-011 ack  output  1  transaction complete; data_out valid when the transaction was a read.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESPOND, with a four-phase handshake.
REQ-014 IDLE: on a rising edge with re|we high, latch addr, data_in and op, load cnt = LATENCY-1, and go to ACCESS.
REQ-015 Op select: when re and we are both high, the write SHALL win (op = write).
REQ-016 ACCESS: each edge with cnt != 0 decrements cnt.
REQ-017 ACCESS exit (cnt == 0), write: write the latched data to mem[latched addr] and go to RESPOND.
REQ-018 ACCESS exit (cnt == 0), read: load mem[latched addr] into the data_out register and go to RESPOND.
REQ-019 ACCESS timing: ACCESS occupies exactly LATENCY cycles.
REQ-020 ack SHALL be high exactly while state == RESPOND. It first rises at edge E0+LATENCY, where E0 is the accept edge.
REQ-021 RESPOND: remain in RESPOND while re|we is high; on the first edge with re == 0 and we == 0, go to IDLE.
REQ-022 Minimum request gap: consecutive requests are therefore separated by at least one IDLE cycle.
REQ-023 Requests in ACCESS: re, we, addr and data_in SHALL be ignored, with no queuing; changes to addr or data_in do not affect the transaction in flight.
REQ-024 data_out SHALL hold its value until the next read completes; writes SHALL NOT change data_out.
REQ-025 Read-after-write to the same address SHALL return the newly written data.
REQ-026 Address range: the full 0..DEPTH-1 range is addressable with no wrap or aliasing.
REQ-027 ack and busy SHALL be registered-state decodes, with no combinational path from re or we.

Reset
REQ-028 rst high SHALL immediately force state = IDLE, cnt = 0, data_out = 0, ack = 0, busy = 0.
REQ-029 Reset during ACCESS SHALL abort the transaction: no array write and no ack.
REQ-030 Memory array contents SHALL NOT be cleared by reset.
REQ-031 On the first edge after rst falls, a held re or we SHALL be accepted as a new request.

Structure
REQ-032 Shared package ram_pkg: state enum ram_state_t (IDLE, ACCESS, RESPOND) and the LATENCY range-limit constants.
REQ-033 The data_out register SHALL be an instance of the existing component_register sub-module, enabled by read completion; the counter and FSM stay inline.

Verification
REQ-034 Write then read, LATENCY=4:
- we=1, addr=0x10, data_in=0xA5 -> ack rises 4 cycles after accept; data_out stays 0.
- Drop we; then re=1, addr=0x10 -> ack after 4 cycles with data_out = 0xA5.
REQ-035 Simultaneous re=we=1, addr=0x20, data_in=0x3C -> a write is performed, data_out is unchanged, and a later read of 0x20 returns 0x3C.
REQ-036 Address change mid-access: accept a read of 0x10 (holding 0xA5), then change addr to 0x11 during ACCESS -> data_out = 0xA5.
REQ-037 Handshake hold: keep re=1 for 10 cycles after ack -> ack stays high, busy stays high, and no second access occurs. Drop re -> IDLE on the next edge.
REQ-038 Reset abort: rst pulse at cycle 2 of a write of 0xFF to 0x30 -> ack never rises, busy = 0 immediately, and mem[0x30] keeps its prior value (0x00 if written earlier).
REQ-039 Boundaries: write/read addr 0x00 and 0xFF with data 0x01 and 0x80 -> each readback matches, with no aliasing. Repeat with LATENCY=1 -> ack one cycle after accept.
